// File: rtl/reg_file_wb.sv
// Write-back register file: two combinational read ports, a registered debug port and a write trace.
// Build option: define RF_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic [ADDR_W-1:0] dbgReg,
    output logic [DATA_W-1:0] dbgData,
    output logic              lastWrValid,
    output logic [ADDR_W-1:0] lastWrReg,
    output logic [DATA_W-1:0] lastWrData,
    output logic [CNT_W-1:0]  wrCount
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] dbg_q, dbg_d;
    logic              lwv_q, lwv_d;
    logic [ADDR_W-1:0] lwr_q, lwr_d;
    logic [DATA_W-1:0] lwd_q, lwd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_acc_s;
    logic [DATA_W-1:0] rd1_s, rd2_s;

    // A write only counts when strobed and aimed at a real register.
    always_comb begin
        wr_acc_s = regWrite && (writeReg != {ADDR_W{1'b0}});
    end

    // Next-state for the register array and the write trace.
    always_comb begin
        regs_d = regs_q;
        lwv_d  = lwv_q;
        lwr_d  = lwr_q;
        lwd_d  = lwd_q;
        cnt_d  = cnt_q;
        if (wr_acc_s) begin
            regs_d[writeReg] = writeData;
            lwv_d            = 1'b1;
            lwr_d            = writeReg;
            lwd_d            = writeData;
            cnt_d            = cnt_q + CNT_W'(1);
        end else begin
            regs_d = regs_q;
        end
    end

    // Debug sample sees the pre-write array contents; no forwarding here.
    always_comb begin
        if (dbgReg == {ADDR_W{1'b0}}) begin
            dbg_d = {DATA_W{1'b0}};
        end else begin
            dbg_d = regs_q[dbgReg];
        end
    end

    // Read port 1 selection, with optional write-first forwarding.
    always_comb begin
        rd1_s = {DATA_W{1'b0}};
`ifdef RF_BYPASS_EN
        if (wr_acc_s && (writeReg == readReg1)) begin
            rd1_s = writeData;
        end else if (readReg1 == {ADDR_W{1'b0}}) begin
            rd1_s = {DATA_W{1'b0}};
        end else begin
            rd1_s = regs_q[readReg1];
        end
`else
        if (readReg1 == {ADDR_W{1'b0}}) begin
            rd1_s = {DATA_W{1'b0}};
        end else begin
            rd1_s = regs_q[readReg1];
        end
`endif
    end

    // Read port 2 selection, mirror of port 1.
    always_comb begin
        rd2_s = {DATA_W{1'b0}};
`ifdef RF_BYPASS_EN
        if (wr_acc_s && (writeReg == readReg2)) begin
            rd2_s = writeData;
        end else if (readReg2 == {ADDR_W{1'b0}}) begin
            rd2_s = {DATA_W{1'b0}};
        end else begin
            rd2_s = regs_q[readReg2];
        end
`else
        if (readReg2 == {ADDR_W{1'b0}}) begin
            rd2_s = {DATA_W{1'b0}};
        end else begin
            rd2_s = regs_q[readReg2];
        end
`endif
    end

    // State registers; asynchronous reset clears everything, including an in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            dbg_q <= {DATA_W{1'b0}};
            lwv_q <= 1'b0;
            lwr_q <= {ADDR_W{1'b0}};
            lwd_q <= {DATA_W{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            regs_q <= regs_d;
            dbg_q  <= dbg_d;
            lwv_q  <= lwv_d;
            lwr_q  <= lwr_d;
            lwd_q  <= lwd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign readData1   = rd1_s;
    assign readData2   = rd2_s;
    assign dbgData     = dbg_q;
    assign lastWrValid = lwv_q;
    assign lastWrReg   = lwr_q;
    assign lastWrData  = lwd_q;
    assign wrCount     = cnt_q;

endmodule
